// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath sizes, flag bit positions and ALU mode codes.
// Imported by the register file stage and by the instruction decoder.
package cpu_pkg;

  localparam int NREGS = 16;
  localparam int DW    = 8;
  localparam int AW    = $clog2(NREGS);

  // Bit positions inside the packed {C,Z,N} flag vector.
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // ALU operation codes, shared with the decoder.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SBC = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;
  localparam logic [3:0] ALU_SHL = 4'd8;
  localparam logic [3:0] ALU_SHR = 4'd9;
  localparam logic [3:0] ALU_CMP = 4'd10;
  localparam logic [3:0] ALU_MOV = 4'd11;

  function automatic logic [2:0] pack_flags(input logic c, input logic z, input logic n);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/regfile_array.sv
// NREGS x DW register storage: two asynchronous read ports, one synchronous
// write port, synchronous clear on rst.
module regfile_array
  import cpu_pkg::*;
#(
  parameter int NREGS_P = NREGS,
  parameter int DW_P    = DW,
  parameter int AW_P    = $clog2(NREGS_P)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW_P-1:0] waddr,
  input  logic [DW_P-1:0] wdata,
  input  logic [AW_P-1:0] raddr_a,
  input  logic [AW_P-1:0] raddr_b,
  output logic [DW_P-1:0] rdata_a,
  output logic [DW_P-1:0] rdata_b
);

  logic [NREGS_P-1:0][DW_P-1:0] mem_q;
  logic [NREGS_P-1:0][DW_P-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_writeback_regfile.sv
// Register file and status-flag stage around the 8-bit ALU: operand read ports
// with forwarding, one-deep writeback pipeline register, and the C/Z/N flags.
module alu_writeback_regfile
  import cpu_pkg::*;
#(
  parameter int NREGS_P = NREGS,
  parameter int DW_P    = DW,
  parameter int AW_P    = $clog2(NREGS_P)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW_P-1:0] rd_addr_a,
  input  logic [AW_P-1:0] rd_addr_b,
  output logic [DW_P-1:0] rd_data_a,
  output logic [DW_P-1:0] rd_data_b,
  input  logic [DW_P-1:0] alu_out,
  input  logic            alu_cout,
  input  logic            alu_zout,
  input  logic            alu_nout,
  input  logic            wb_valid,
  input  logic            wb_reg_en,
  input  logic            wb_flags_en,
  input  logic [AW_P-1:0] wb_addr,
  input  logic            stall,
  input  logic            flags_restore_en,
  input  logic [2:0]      flags_restore,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_n
);

  // Handshake: wb_valid qualifies the ALU inputs in a cycle; stall=1 means the
  // stage does not accept them and upstream holds them until stall=0.
  logic            stage_valid_q, stage_valid_d;
  logic [AW_P-1:0] stage_addr_q,  stage_addr_d;
  logic [DW_P-1:0] stage_data_q,  stage_data_d;
  logic [2:0]      flags_q,       flags_d;

  logic [DW_P-1:0] arr_data_a;
  logic [DW_P-1:0] arr_data_b;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    if (!stall) begin
      stage_valid_d = wb_valid & wb_reg_en;
      stage_addr_d  = wb_addr;
      stage_data_d  = alu_out;
    end
  end

  // Restore beats a same-cycle ALU update; flags bypass the stage register
  // so the very next instruction's carry-in already sees them.
  always_comb begin
    flags_d = flags_q;
    if (flags_restore_en) begin
      flags_d = flags_restore;
    end else if (!stall && wb_valid && wb_flags_en) begin
      flags_d = pack_flags(alu_cout, alu_zout, alu_nout);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      flags_q       <= 3'b000;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      flags_q       <= flags_d;
    end
  end

  // While stalled the held stage commits again each cycle, which is harmless.
  regfile_array #(
    .NREGS_P (NREGS_P),
    .DW_P    (DW_P),
    .AW_P    (AW_P)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (stage_valid_q),
    .waddr   (stage_addr_q),
    .wdata   (stage_data_q),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (arr_data_a),
    .rdata_b (arr_data_b)
  );

  assign rd_data_a = (stage_valid_q && stage_addr_q == rd_addr_a) ? stage_data_q : arr_data_a;
  assign rd_data_b = (stage_valid_q && stage_addr_q == rd_addr_b) ? stage_data_q : arr_data_b;

  assign flag_c = flags_q[FLAG_C];
  assign flag_z = flags_q[FLAG_Z];
  assign flag_n = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Bench for alu_writeback_regfile: directed scenarios followed by random
// traffic checked against a behavioural model of registers, pending write and flags.
module tb_alu_writeback_regfile;

  logic       clk;
  logic       rst;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic [7:0] alu_out;
  logic       alu_cout, alu_zout, alu_nout;
  logic       wb_valid, wb_reg_en, wb_flags_en;
  logic [3:0] wb_addr;
  logic       stall;
  logic       flags_restore_en;
  logic [2:0] flags_restore;
  logic       flag_c, flag_z, flag_n;

  int checks;
  int errors;

  // Behavioural model: architectural registers, writes not yet in the array, flags.
  logic [7:0] m_regs [16];
  logic [11:0] exp_q [$];   // {addr, data} of a result visible only by forwarding
  logic [2:0] m_flags;

  alu_writeback_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .rd_addr_a        (rd_addr_a),
    .rd_addr_b        (rd_addr_b),
    .rd_data_a        (rd_data_a),
    .rd_data_b        (rd_data_b),
    .alu_out          (alu_out),
    .alu_cout         (alu_cout),
    .alu_zout         (alu_zout),
    .alu_nout         (alu_nout),
    .wb_valid         (wb_valid),
    .wb_reg_en        (wb_reg_en),
    .wb_flags_en      (wb_flags_en),
    .wb_addr          (wb_addr),
    .stall            (stall),
    .flags_restore_en (flags_restore_en),
    .flags_restore    (flags_restore),
    .flag_c           (flag_c),
    .flag_z           (flag_z),
    .flag_n           (flag_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [7:0] v;
    v = m_regs[a];
    foreach (exp_q[i]) begin
      if (exp_q[i][11:8] == a) v = exp_q[i][7:0];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    wb_valid = 1'b0; wb_reg_en = 1'b0; wb_flags_en = 1'b0; wb_addr = 4'd0;
    alu_out = 8'h00; alu_cout = 1'b0; alu_zout = 1'b0; alu_nout = 1'b0;
    stall = 1'b0; flags_restore_en = 1'b0; flags_restore = 3'b000;
  endtask

  task automatic drive_wb(input logic reg_en, input logic flags_en, input logic [3:0] a,
                          input logic [7:0] d, input logic [2:0] czn);
    wb_valid = 1'b1; wb_reg_en = reg_en; wb_flags_en = flags_en; wb_addr = a;
    alu_out = d; {alu_cout, alu_zout, alu_nout} = czn;
  endtask

  // One clock edge; the model advances from the inputs applied before it.
  task automatic tick();
    logic [7:0]  n_regs [16];
    logic [11:0] n_pend [$];
    logic [2:0]  n_flags;
    n_regs  = m_regs;
    n_flags = m_flags;
    n_pend  = exp_q;
    if (rst) begin
      foreach (n_regs[i]) n_regs[i] = 8'h00;
      n_pend.delete();
      n_flags = 3'b000;
    end else begin
      foreach (exp_q[i]) n_regs[exp_q[i][11:8]] = exp_q[i][7:0];
      if (!stall) begin
        n_pend.delete();
        if (wb_valid && wb_reg_en) n_pend.push_back({wb_addr, alu_out});
      end
      if (flags_restore_en) n_flags = flags_restore;
      else if (!stall && wb_valid && wb_flags_en) n_flags = {alu_cout, alu_zout, alu_nout};
    end
    @(posedge clk);
    #1;
    m_regs  = n_regs;
    exp_q   = n_pend;
    m_flags = n_flags;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rd_a"}, rd_data_a, m_read(rd_addr_a));
    chk({tag, "_rd_b"}, rd_data_b, m_read(rd_addr_b));
    chk({tag, "_flags"}, {5'd0, flag_c, flag_z, flag_n}, {5'd0, m_flags});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    foreach (m_regs[i]) m_regs[i] = 8'hxx;
    m_flags = 3'bxxx;
    drive_idle();
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_rd_a", rd_data_a, 8'h00);
    chk("reset_flags", {5'd0, flag_c, flag_z, flag_n}, 8'h00);

    // 1. Reset clears registers and flags after r3 = 0x5A
    drive_wb(1'b1, 1'b1, 4'd3, 8'h5A, 3'b111);
    tick(); drive_idle(); tick();
    rd_addr_a = 4'd3; #1;
    chk("pre_reset_r3", rd_data_a, 8'h5A);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("reset_r3", rd_data_a, 8'h00);
    chk("reset_flags2", {5'd0, flag_c, flag_z, flag_n}, 8'h00);

    // 2. Write r5 then read via forwarding and via the array
    drive_wb(1'b1, 1'b0, 4'd5, 8'hA7, 3'b000);
    tick(); drive_idle();
    rd_addr_a = 4'd5; rd_addr_b = 4'd5; #1;
    chk("fwd_r5_a", rd_data_a, 8'hA7);
    chk("fwd_r5_b", rd_data_b, 8'hA7);
    tick(); #1;
    chk("arr_r5_a", rd_data_a, 8'hA7);
    tick(); #1;
    chk("arr_r5_hold", rd_data_a, 8'hA7);

    // 3. Back-to-back writes to r2
    drive_wb(1'b1, 1'b0, 4'd2, 8'h11, 3'b000);
    tick();
    drive_wb(1'b1, 1'b0, 4'd2, 8'h22, 3'b000);
    rd_addr_a = 4'd2; #1;
    chk("b2b_first", rd_data_a, 8'h11);
    tick(); drive_idle(); #1;
    chk("b2b_second", rd_data_a, 8'h22);
    tick(); #1;
    chk("b2b_array", rd_data_a, 8'h22);

    // 4. CMP: flags only
    drive_wb(1'b0, 1'b1, 4'd2, 8'h99, 3'b101);
    tick(); drive_idle(); #1;
    chk("cmp_flags", {5'd0, flag_c, flag_z, flag_n}, 8'h05);
    chk("cmp_r2", rd_data_a, 8'h22);
    tick(); #1;
    chk("cmp_r2_later", rd_data_a, 8'h22);

    // 5. Stall blocks capture and flags; upstream holds until release
    drive_wb(1'b1, 1'b1, 4'd7, 8'hFF, 3'b110);
    stall = 1'b1;
    rd_addr_a = 4'd7;
    tick(); tick(); #1;
    chk("stall_r7", rd_data_a, 8'h00);
    chk("stall_flags", {5'd0, flag_c, flag_z, flag_n}, 8'h05);
    stall = 1'b0;
    tick(); drive_idle(); #1;
    chk("unstall_r7_fwd", rd_data_a, 8'hFF);
    chk("unstall_flags", {5'd0, flag_c, flag_z, flag_n}, 8'h06);
    tick(); #1;
    chk("unstall_r7_arr", rd_data_a, 8'hFF);

    // 6. Restore beats a same-cycle ALU flag update
    drive_wb(1'b0, 1'b1, 4'd0, 8'h00, 3'b111);
    flags_restore_en = 1'b1; flags_restore = 3'b010;
    tick(); drive_idle(); #1;
    chk("restore_prio", {5'd0, flag_c, flag_z, flag_n}, 8'h02);

    // Random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst              = ($urandom_range(0, 59) == 0);
      stall            = ($urandom_range(0, 3) == 0);
      wb_valid         = ($urandom_range(0, 3) != 0);
      wb_reg_en        = ($urandom_range(0, 4) != 0);
      wb_flags_en      = $urandom_range(0, 1);
      wb_addr          = 4'($urandom_range(0, 15));
      alu_out          = 8'($urandom_range(0, 255));
      {alu_cout, alu_zout, alu_nout} = 3'($urandom_range(0, 7));
      flags_restore_en = ($urandom_range(0, 9) == 0);
      flags_restore    = 3'($urandom_range(0, 7));
      rd_addr_a        = 4'($urandom_range(0, 15));
      rd_addr_b        = ($urandom_range(0, 2) == 0) ? wb_addr : 4'($urandom_range(0, 15));
      #1;
      check_model("rand");
      tick();
    end
    rst = 1'b0;
    drive_idle();
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a); #1;
      check_model("final");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
